// File: rtl/user_rq_rr_arbiter.sv
// Purpose: merge N_SRCS request channels onto one rq channel in round-robin order, capping in-flight requests per source.
// Latency: 1 cycle from source accept to m_rq_valid; sustains one request per cycle while m_rq_ready stays high.
// Backpressure: only the winner sees s_rq_ready, and only while the output register is free. Defining USER_RQ_ARB_STATS_EN adds grant and stall counters.
module user_rq_rr_arbiter #(
  parameter int  N_SRCS   = 4,
  parameter int  REQ_BITS = 128,
  parameter int  MAX_OUTS = 8,
  localparam int SRC_BITS = (N_SRCS > 1) ? $clog2(N_SRCS) : 1,
  localparam int OUT_BITS = ($clog2(MAX_OUTS + 1) > 0) ? $clog2(MAX_OUTS + 1) : 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [N_SRCS-1:0]            s_rq_valid,
  output logic [N_SRCS-1:0]            s_rq_ready,
  input  logic [N_SRCS*REQ_BITS-1:0]   s_rq_data,
  output logic                         m_rq_valid,
  input  logic                         m_rq_ready,
  output logic [REQ_BITS-1:0]          m_rq_data,
  output logic [SRC_BITS-1:0]          m_rq_src,
  input  logic                         done_valid,
  input  logic [SRC_BITS-1:0]          done_src,
  output logic [N_SRCS*OUT_BITS-1:0]   outs_cnt,
  output logic                         err_underflow
`ifdef USER_RQ_ARB_STATS_EN
  ,
  output logic [N_SRCS*32-1:0]         grant_cnt,
  output logic [31:0]                  stall_cnt
`endif
);

  typedef logic [REQ_BITS-1:0] req_t;
  typedef logic [OUT_BITS-1:0] cnt_t;
  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SRC_BITS-1:0] rr_ptr;
  cnt_t                cnt      [N_SRCS];
  req_t                src_word [N_SRCS];
  logic [N_SRCS-1:0]   eligible;
  logic                any_elig;
  logic                out_free;
  logic                grant;
  logic [SRC_BITS-1:0] win_idx;
  logic [N_SRCS-1:0]   cnt_inc;
  logic [N_SRCS-1:0]   cnt_dec;
  logic                done_hit;
  logic                done_zero;
  logic                err_set;

  // Unpack source words, flag sources that are requesting and still under their in-flight cap.
  always_comb begin
    for (int i = 0; i < N_SRCS; i++) begin
      src_word[i] = s_rq_data[i*REQ_BITS +: REQ_BITS];
      eligible[i] = s_rq_valid[i] && (cnt[i] < cnt_t'(MAX_OUTS));
      outs_cnt[i*OUT_BITS +: OUT_BITS] = cnt[i];
    end
  end

  // Scan from rr_ptr upward (wrapping) and pick the first eligible source.
  always_comb begin
    int idx;
    any_elig = 1'b0;
    win_idx  = '0;
    idx      = 0;
    for (int k = 0; k < N_SRCS; k++) begin
      idx = (int'(rr_ptr) + k) % N_SRCS;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        win_idx  = SRC_BITS'(idx);
      end
    end
  end

  // The output register can take a new word when empty or being drained this cycle.
  always_comb begin
    out_free = !areset && ((state == ST_IDLE) || m_rq_ready);
    grant    = out_free && any_elig;
    for (int i = 0; i < N_SRCS; i++) begin
      s_rq_ready[i] = grant && (win_idx == SRC_BITS'(i));
    end
  end

  // Decode per-source increment/decrement and detect done pulses that cannot be matched to a request.
  always_comb begin
    done_hit  = 1'b0;
    done_zero = 1'b0;
    for (int i = 0; i < N_SRCS; i++) begin
      cnt_inc[i] = grant && (win_idx == SRC_BITS'(i));
      cnt_dec[i] = 1'b0;
      if (done_valid && (done_src == SRC_BITS'(i))) begin
        done_hit = 1'b1;
        if (cnt[i] == '0) begin
          done_zero = 1'b1;
        end else begin
          cnt_dec[i] = 1'b1;
        end
      end
    end
    err_set = done_valid && (!done_hit || done_zero);
  end

  // Next state and output valid: hold in ST_SEND while the mux stalls or refills back-to-back.
  always_comb begin
    state_nxt  = state;
    m_rq_valid = (state == ST_SEND);
    case (state)
      ST_IDLE: begin
        if (grant) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (m_rq_ready) state_nxt = grant ? ST_SEND : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture the granted word and advance the round-robin pointer past the winner.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_rq_data <= '0;
      m_rq_src  <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      m_rq_data <= src_word[win_idx];
      m_rq_src  <= win_idx;
      rr_ptr    <= (win_idx == SRC_BITS'(N_SRCS - 1)) ? '0 : win_idx + SRC_BITS'(1);
    end
  end

  // In-flight counters: a grant and a done for the same source in one cycle cancel out.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_SRCS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRCS; i++) begin
        case ({cnt_inc[i], cnt_dec[i]})
          2'b10:   cnt[i] <= cnt[i] + cnt_t'(1);
          2'b01:   cnt[i] <= cnt[i] - cnt_t'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Sticky error for unmatched done pulses.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)       err_underflow <= 1'b0;
    else if (err_set) err_underflow <= 1'b1;
  end

`ifdef USER_RQ_ARB_STATS_EN
  logic [31:0] gcnt [N_SRCS];

  // Per-source grant counters, free-running and wrapping.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_SRCS; i++) gcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRCS; i++) begin
        if (cnt_inc[i]) gcnt[i] <= gcnt[i] + 32'd1;
      end
    end
  end

  // Count cycles where a held request is stalled by the mux.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                                  stall_cnt <= '0;
    else if ((state == ST_SEND) && !m_rq_ready) stall_cnt <= stall_cnt + 32'd1;
  end

  // Flatten grant counters onto the output bus.
  always_comb begin
    for (int i = 0; i < N_SRCS; i++) grant_cnt[i*32 +: 32] = gcnt[i];
  end
`endif

endmodule

// File: tb/tb_user_rq_rr_arbiter.sv
// Purpose: self-checking bench for user_rq_rr_arbiter against a transaction-level reference model.
// Latency: model predicts handshakes per cycle and the registered output one cycle later.
// Backpressure: random and directed m_rq_ready stalls; define USER_RQ_ARB_STATS_EN to also check stats.
module tb_user_rq_rr_arbiter;
  localparam int N   = 4;
  localparam int RB  = 128;
  localparam int MAX = 8;
  localparam int SB  = 2;
  localparam int OB  = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N-1:0]      s_rq_valid;
  logic [N-1:0]      s_rq_ready;
  logic [N*RB-1:0]   s_rq_data;
  logic              m_rq_valid;
  logic              m_rq_ready;
  logic [RB-1:0]     m_rq_data;
  logic [SB-1:0]     m_rq_src;
  logic              done_valid;
  logic [SB-1:0]     done_src;
  logic [N*OB-1:0]   outs_cnt;
  logic              err_underflow;
`ifdef USER_RQ_ARB_STATS_EN
  logic [N*32-1:0]   grant_cnt;
  logic [31:0]       stall_cnt;
`endif

  user_rq_rr_arbiter #(.N_SRCS(N), .REQ_BITS(RB), .MAX_OUTS(MAX)) dut (
    .aclk(aclk), .areset(areset),
    .s_rq_valid(s_rq_valid), .s_rq_ready(s_rq_ready), .s_rq_data(s_rq_data),
    .m_rq_valid(m_rq_valid), .m_rq_ready(m_rq_ready), .m_rq_data(m_rq_data), .m_rq_src(m_rq_src),
    .done_valid(done_valid), .done_src(done_src),
    .outs_cnt(outs_cnt), .err_underflow(err_underflow)
`ifdef USER_RQ_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // Reference model: in-flight counts, round-robin pointer, held output word.
  int          m_cnt [N];
  int          m_ptr;
  bit          m_busy;
  logic [RB-1:0] m_held;
  int          m_hsrc;
  bit          m_err;
  int          m_gcnt [N];
  int          m_stall;
  int          acc_q [$];
  int          obs_grants;

  function automatic logic [RB-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_gcnt[i] = 0;
    end
    m_ptr = 0; m_busy = 0; m_held = '0; m_hsrc = 0; m_err = 0; m_stall = 0;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) s_rq_data[i*RB +: RB] = rand_word();
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    s_rq_valid = '0; m_rq_ready = 1'b0; done_valid = 1'b0; done_src = '0;
    randomize_data();
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    acc_q.delete();
    obs_grants = 0;
  endtask

  // One clock cycle: compare DUT against the model at negedge, then advance the model.
  task automatic step();
    int w;
    bit found, free, grant_m;
    logic [N-1:0] exp_rdy;
    logic [N*OB-1:0] exp_outs;
    @(negedge aclk);
    free  = !m_busy || m_rq_ready;
    found = 0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!found && s_rq_valid[idx] && (m_cnt[idx] < MAX)) begin
        found = 1;
        w     = idx;
      end
    end
    grant_m = free && found;
    exp_rdy = '0;
    if (grant_m) exp_rdy[w] = 1'b1;
    for (int i = 0; i < N; i++) exp_outs[i*OB +: OB] = OB'(m_cnt[i]);

    checks++;
    if (s_rq_ready !== exp_rdy) begin
      errors++;
      $display("FAIL s_rq_ready t=%0t got=%b exp=%b", $time, s_rq_ready, exp_rdy);
    end
    checks++;
    if (m_rq_valid !== m_busy) begin
      errors++;
      $display("FAIL m_rq_valid t=%0t got=%b exp=%b", $time, m_rq_valid, m_busy);
    end
    if (m_busy) begin
      checks++;
      if (m_rq_data !== m_held) begin
        errors++;
        $display("FAIL m_rq_data t=%0t got=%h exp=%h", $time, m_rq_data, m_held);
      end
      checks++;
      if (m_rq_src !== SB'(m_hsrc)) begin
        errors++;
        $display("FAIL m_rq_src t=%0t got=%0d exp=%0d", $time, m_rq_src, m_hsrc);
      end
    end
    checks++;
    if (outs_cnt !== exp_outs) begin
      errors++;
      $display("FAIL outs_cnt t=%0t got=%h exp=%h", $time, outs_cnt, exp_outs);
    end
    checks++;
    if (err_underflow !== m_err) begin
      errors++;
      $display("FAIL err_underflow t=%0t got=%b exp=%b", $time, err_underflow, m_err);
    end
`ifdef USER_RQ_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      checks++;
      if (grant_cnt[i*32 +: 32] !== 32'(m_gcnt[i])) begin
        errors++;
        $display("FAIL grant_cnt[%0d] t=%0t got=%0d exp=%0d", i, $time, grant_cnt[i*32 +: 32], m_gcnt[i]);
      end
    end
    checks++;
    if (stall_cnt !== 32'(m_stall)) begin
      errors++;
      $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, m_stall);
    end
`endif

    // Observations of what the DUT actually did this cycle.
    if (m_rq_valid && m_rq_ready) acc_q.push_back(int'(m_rq_src));
    if ((s_rq_valid & s_rq_ready) != '0) obs_grants++;

    // Advance the model: done uses the count before this cycle's grant.
    if (m_busy && !m_rq_ready) m_stall++;
    if (done_valid) begin
      if (m_cnt[done_src] == 0) m_err = 1;
      else m_cnt[done_src]--;
    end
    if (grant_m) begin
      m_cnt[w]++;
      m_gcnt[w]++;
      m_held = s_rq_data[w*RB +: RB];
      m_hsrc = w;
      m_ptr  = (w + 1) % N;
      m_busy = 1;
    end else if (m_busy && m_rq_ready) begin
      m_busy = 0;
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_rq_valid = '1; m_rq_ready = 1'b1; done_valid = 1'b0; done_src = '0;
    randomize_data();
    #12;
    checks++;
    if (m_rq_valid !== 1'b0) begin errors++; $display("FAIL reset_m_rq_valid got=%b exp=0", m_rq_valid); end
    checks++;
    if (s_rq_ready !== '0) begin errors++; $display("FAIL reset_s_rq_ready got=%b exp=0", s_rq_ready); end
    checks++;
    if (m_rq_data !== '0) begin errors++; $display("FAIL reset_m_rq_data got=%h exp=0", m_rq_data); end
    checks++;
    if (m_rq_src !== '0) begin errors++; $display("FAIL reset_m_rq_src got=%0d exp=0", m_rq_src); end
    checks++;
    if (outs_cnt !== '0) begin errors++; $display("FAIL reset_outs_cnt got=%h exp=0", outs_cnt); end
    checks++;
    if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
    apply_reset();
  endtask

  task automatic test_round_robin();
    apply_reset();
    s_rq_valid = '1;
    m_rq_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      randomize_data();
      done_valid = m_busy;
      done_src   = SB'(m_hsrc);
      step();
    end
    done_valid = 1'b0;
    checks++;
    if (acc_q.size() != 11) begin
      errors++;
      $display("FAIL rr_accept_count got=%0d exp=11", acc_q.size());
    end
    for (int k = 0; k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k] != k % N) begin
        errors++;
        $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, acc_q[k], k % N);
      end
    end
  endtask

  task automatic test_max_outs();
    apply_reset();
    s_rq_valid = 4'b0100;
    m_rq_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      randomize_data();
      step();
    end
    checks++;
    if (obs_grants != MAX) begin errors++; $display("FAIL max_grants got=%0d exp=%0d", obs_grants, MAX); end
    checks++;
    if (outs_cnt[2*OB +: OB] !== OB'(MAX)) begin
      errors++; $display("FAIL max_cnt2 got=%0d exp=%0d", outs_cnt[2*OB +: OB], MAX);
    end
    done_valid = 1'b1; done_src = 2'd2;
    step();
    done_valid = 1'b0;
    checks++;
    if (obs_grants != MAX) begin errors++; $display("FAIL max_grant_on_done got=%0d exp=%0d", obs_grants, MAX); end
    step();
    checks++;
    if (obs_grants != MAX + 1) begin errors++; $display("FAIL max_ninth_grant got=%0d exp=%0d", obs_grants, MAX + 1); end
  endtask

  task automatic test_stall();
    logic [N*OB-1:0] exp_outs;
    apply_reset();
    s_rq_valid = '1;
    m_rq_ready = 1'b1;
    step();
    m_rq_ready = 1'b0;
    obs_grants = 0;
    for (int c = 0; c < 5; c++) begin
      randomize_data();
      step();
    end
    checks++;
    if (obs_grants != 0) begin errors++; $display("FAIL stall_grants got=%0d exp=0", obs_grants); end
    exp_outs = '0;
    exp_outs[0 +: OB] = OB'(1);
    checks++;
    if (outs_cnt !== exp_outs) begin errors++; $display("FAIL stall_outs got=%h exp=%h", outs_cnt, exp_outs); end
    m_rq_ready = 1'b1;
    step();
    checks++;
    if (obs_grants != 1) begin errors++; $display("FAIL stall_release_grant got=%0d exp=1", obs_grants); end
    checks++;
    if (acc_q.size() != 1 || acc_q[0] != 0) begin
      errors++; $display("FAIL stall_release_accept got_size=%0d exp src 0", acc_q.size());
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    s_rq_valid = 4'b0010;
    m_rq_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (outs_cnt[1*OB +: OB] !== OB'(3)) begin errors++; $display("FAIL same_pre got=%0d exp=3", outs_cnt[1*OB +: OB]); end
    done_valid = 1'b1; done_src = 2'd1;
    step();
    done_valid = 1'b0;
    s_rq_valid = '0;
    step();
    checks++;
    if (outs_cnt[1*OB +: OB] !== OB'(3)) begin errors++; $display("FAIL same_cycle got=%0d exp=3", outs_cnt[1*OB +: OB]); end
    done_valid = 1'b1; done_src = 2'd0;
    step();
    done_valid = 1'b0;
    checks++;
    if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag got=%b exp=1", err_underflow); end
    checks++;
    if (outs_cnt[0 +: OB] !== OB'(0)) begin errors++; $display("FAIL underflow_cnt got=%0d exp=0", outs_cnt[0 +: OB]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m_rq_ready = 1'b1;
    s_rq_valid = 4'b1000; for (int c = 0; c < 3; c++) step();
    s_rq_valid = 4'b0001; for (int c = 0; c < 2; c++) step();
    s_rq_valid = 4'b0010; step();
    m_rq_ready = 1'b0;
    s_rq_valid = '1;
    step();
    checks++;
    if (outs_cnt !== 16'h3012) begin errors++; $display("FAIL mid_pre_cnt got=%h exp=3012", outs_cnt); end
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (m_rq_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", m_rq_valid); end
    checks++;
    if (outs_cnt !== '0) begin errors++; $display("FAIL mid_cnt got=%h exp=0", outs_cnt); end
    @(posedge aclk); #1;
    areset = 1'b0;
    model_reset();
    m_rq_ready = 1'b1;
    #1;
    checks++;
    if (s_rq_ready !== 4'b0001) begin errors++; $display("FAIL mid_scan_from0 got=%b exp=0001", s_rq_ready); end
    step();
    step();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      s_rq_valid = N'($urandom);
      m_rq_ready = ($urandom_range(0, 3) != 0);
      done_valid = ($urandom_range(0, 9) < 4);
      done_src   = SB'($urandom_range(0, N - 1));
      randomize_data();
      step();
    end
    done_valid = 1'b0;
  endtask

`ifdef USER_RQ_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    s_rq_valid = 4'b1000;
    m_rq_ready = 1'b1;
    for (int c = 0; c < 40 && m_gcnt[3] < 10; c++) begin
      done_valid = (m_cnt[3] > 0);
      done_src   = 2'd3;
      step();
    end
    done_valid = 1'b0;
    s_rq_valid = '0;
    m_rq_ready = 1'b0;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if (grant_cnt[3*32 +: 32] !== 32'd10) begin errors++; $display("FAIL stats_grant3 got=%0d exp=10", grant_cnt[3*32 +: 32]); end
    checks++;
    if (stall_cnt !== 32'd4) begin errors++; $display("FAIL stats_stall got=%0d exp=4", stall_cnt); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_max_outs();
    test_stall();
    test_same_cycle();
    test_reset_mid();
    test_random();
`ifdef USER_RQ_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
